// File: rtl/mips_fetch_queue.sv
// Instruction fetch front end: one outstanding word request, responses buffered with PCs in a DEPTH-entry FIFO.
// Grant-to-output latency 2 cycles; requests stall while the FIFO is full, and redirect flushes the FIFO and drops in-flight data.
module mips_fetch_queue #(
   parameter int                DATA_W   = 32,
   parameter int                ADDR_W   = 32,
   parameter int                DEPTH    = 4,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter int                PC_INC   = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   output logic                         imem_req,
   output logic [ADDR_W-1:0]            imem_addr,
   input  logic                         imem_gnt,
   input  logic                         imem_rvalid,
   input  logic [DATA_W-1:0]            imem_rdata,
   input  logic                         redirect,
   input  logic [ADDR_W-1:0]            redirect_pc,
   output logic                         out_valid,
   output logic [DATA_W-1:0]            out_inst,
   output logic [ADDR_W-1:0]            out_pc,
   input  logic                         out_ready,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DROP} state_t;

   state_t            state_q;
   logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_W-1:0] pend_pc_q;
   logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]     count_q, count_d;
   logic [DATA_W-1:0] inst_mem_q [DEPTH];
   logic [ADDR_W-1:0] pc_mem_q   [DEPTH];
   logic              fire, push, pop;

   assign imem_req  = rst && (state_q == IDLE) && (count_q < CW'(DEPTH)) && !redirect;
   assign imem_addr = fetch_pc_q;
   assign fire      = imem_req && imem_gnt;
   assign push      = (state_q == WAIT) && imem_rvalid && !redirect;
   assign out_valid = (count_q != '0);
   assign pop       = out_valid && out_ready && !redirect;
   assign out_inst  = inst_mem_q[rd_ptr_q];
   assign out_pc    = pc_mem_q[rd_ptr_q];
   assign count     = count_q;

   always_comb begin
      fetch_pc_d = fetch_pc_q;
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      if (redirect) begin
         fetch_pc_d = redirect_pc;
         rd_ptr_d   = '0;
         wr_ptr_d   = '0;
         count_d    = '0;
      end else begin
         if (fire) fetch_pc_d = fetch_pc_q + ADDR_W'(PC_INC);
         if (push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         if (push && !pop)      count_d = count_q + CW'(1);
         else if (pop && !push) count_d = count_q - CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q    <= IDLE;
         fetch_pc_q <= RESET_PC;
         pend_pc_q  <= '0;
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
      end else begin
         fetch_pc_q <= fetch_pc_d;
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         if (fire) pend_pc_q <= fetch_pc_q;
         // A redirect racing an outstanding request must still swallow that request's response.
         case (state_q)
            IDLE:    if (fire) state_q <= WAIT;
            WAIT: begin
               if (redirect && !imem_rvalid) state_q <= DROP;
               else if (imem_rvalid)         state_q <= IDLE;
            end
            DROP:    if (imem_rvalid) state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         inst_mem_q[wr_ptr_q] <= imem_rdata;
         pc_mem_q[wr_ptr_q]   <= pend_pc_q;
      end
   end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Bench for mips_fetch_queue: variable-latency memory returning data=addr, scoreboard of granted PCs.
module tb_mips_fetch_queue;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;
   logic [2:0]  count;

   int          passed = 0;
   int          total  = 0;
   int          lat    = 1;
   int          mcnt   = 0;
   logic [31:0] maddr  = '0;
   logic [31:0] exp_q [$];

   mips_fetch_queue dut (
      .clk        (clk),
      .rst        (rst),
      .imem_req   (imem_req),
      .imem_addr  (imem_addr),
      .imem_gnt   (imem_gnt),
      .imem_rvalid(imem_rvalid),
      .imem_rdata (imem_rdata),
      .redirect   (redirect),
      .redirect_pc(redirect_pc),
      .out_valid  (out_valid),
      .out_inst   (out_inst),
      .out_pc     (out_pc),
      .out_ready  (out_ready),
      .count      (count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory model: inputs settle before the negedge, so the negedge sees what the DUT samples next.
   always @(negedge clk) begin
      imem_rvalid = 1'b0;
      if (mcnt > 0) begin
         mcnt = mcnt - 1;
         if (mcnt == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = maddr;
         end
      end
      if (imem_req && imem_gnt) begin
         mcnt  = lat;
         maddr = imem_addr;
         exp_q.push_back(imem_addr);
      end
   end

   // Scoreboard: every consumed head must be the oldest surviving granted PC.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready && !redirect) begin
         total++;
         if (exp_q.size() == 0) begin
            $display("FAIL sb_unexpected: got pc %h, want no output", out_pc);
         end else begin
            logic [31:0] e;
            e = exp_q.pop_front();
            if (out_pc !== e || out_inst !== e)
               $display("FAIL sb_order: got pc %h inst %h, want %h", out_pc, out_inst, e);
            else passed++;
         end
      end
      if (rst) begin
         total++;
         if (count > 3'd4) $display("FAIL count_bound: got %0d, want <= 4", count);
         else passed++;
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      rst = 1'b0; imem_gnt = 1'b0; redirect = 1'b0; redirect_pc = '0; out_ready = 1'b0;
      imem_rvalid = 1'b0; imem_rdata = '0;
      cyc(2);
      total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
      total++; if (count !== 3'd0) $display("FAIL reset_count: got %0d want 0", count); else passed++;
      rst = 1'b1;
      exp_q.delete();
      #1;
      total++; if (imem_req !== 1'b1) $display("FAIL reset_first_req: got %b want 1", imem_req); else passed++;
      total++; if (imem_addr !== 32'h0) $display("FAIL reset_addr: got %h want 0", imem_addr); else passed++;
   endtask

   task automatic test_stream;
      int k, last;
      out_ready = 1'b1; lat = 1; imem_gnt = 1'b1;
      k = 0; last = 0;
      for (int c = 1; c <= 40 && k < 6; c++) begin
         cyc(1);
         if (out_valid) begin
            total++;
            if (k == 0 && c != 2) $display("FAIL stream_latency: got %0d cycles want 2", c);
            else if (k > 0 && c - last != 2) $display("FAIL stream_gap: got %0d cycles want 2", c - last);
            else passed++;
            total++;
            if (out_pc !== 32'(k * 4) || out_inst !== 32'(k * 4))
               $display("FAIL stream_pc: got pc %h inst %h want %h", out_pc, out_inst, 32'(k * 4));
            else passed++;
            last = c; k++;
         end
      end
      if (k < 6) begin total++; $display("FAIL stream_timeout: got %0d words want 6", k); end
      imem_gnt = 1'b0;
      cyc(6);
      total++; if (exp_q.size() != 0) $display("FAIL stream_drain: got %0d pending want 0", exp_q.size()); else passed++;
   endtask

   task automatic test_full;
      bit hit;
      out_ready = 1'b0; lat = 1; imem_gnt = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 30 && !hit; c++) begin
         cyc(1);
         if (count == 3'd4) hit = 1'b1;
      end
      total++; if (!hit) $display("FAIL full_reach: got count %0d want 4", count); else passed++;
      cyc(2);
      total++; if (imem_req !== 1'b0) $display("FAIL full_req: got %b want 0", imem_req); else passed++;
      total++; if (count !== 3'd4) $display("FAIL full_hold: got %0d want 4", count); else passed++;
      out_ready = 1'b1;
      cyc(1);
      total++; if (count !== 3'd3) $display("FAIL full_pop: got %0d want 3", count); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL full_rereq: got %b want 1", imem_req); else passed++;
      imem_gnt = 1'b0;
      cyc(10);
      total++; if (count !== 3'd0) $display("FAIL full_drain: got %0d want 0", count); else passed++;
      total++; if (exp_q.size() != 0) $display("FAIL full_sb: got %0d pending want 0", exp_q.size()); else passed++;
   endtask

   task automatic test_redirect_wait;
      bit hit;
      out_ready = 1'b1; lat = 4; imem_gnt = 1'b1;
      hit = imem_req;
      for (int c = 0; c < 10 && !hit; c++) begin
         cyc(1);
         hit = imem_req;
      end
      total++; if (!hit) $display("FAIL rdw_req: got %b want 1", imem_req); else passed++;
      cyc(1);
      imem_gnt = 1'b0; redirect = 1'b1; redirect_pc = 32'h100;
      exp_q.delete();
      cyc(1);
      redirect = 1'b0;
      total++; if (out_valid !== 1'b0) $display("FAIL rdw_flush: got %b want 0", out_valid); else passed++;
      imem_gnt = 1'b1; lat = 1;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         cyc(1);
         hit = out_valid;
      end
      total++;
      if (!hit || out_pc !== 32'h100 || out_inst !== 32'h100)
         $display("FAIL rdw_first: got valid %b pc %h inst %h want pc 100", hit, out_pc, out_inst);
      else passed++;
      imem_gnt = 1'b0;
      cyc(6);
   endtask

   task automatic test_redirect_rvalid;
      bit hit;
      out_ready = 1'b0; lat = 1; imem_gnt = 1'b1;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         cyc(1);
         if (count >= 3'd2) hit = 1'b1;
      end
      total++; if (!hit) $display("FAIL rdr_fill: got count %0d want >= 2", count); else passed++;
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
         @(negedge clk); #1;
         hit = imem_rvalid;
      end
      total++; if (!hit || out_valid !== 1'b1) $display("FAIL rdr_align: got rvalid %b valid %b want 1 1", hit, out_valid); else passed++;
      out_ready = 1'b1; redirect = 1'b1; redirect_pc = 32'h200;
      exp_q.delete();
      @(posedge clk); #1;
      redirect = 1'b0;
      total++; if (count !== 3'd0) $display("FAIL rdr_count: got %0d want 0", count); else passed++;
      total++; if (out_valid !== 1'b0) $display("FAIL rdr_valid: got %b want 0", out_valid); else passed++;
      hit = 1'b0;
      for (int c = 0; c < 20 && !hit; c++) begin
         cyc(1);
         hit = out_valid;
      end
      total++;
      if (!hit || out_pc !== 32'h200) $display("FAIL rdr_first: got valid %b pc %h want pc 200", hit, out_pc);
      else passed++;
      imem_gnt = 1'b0;
      cyc(6);
   endtask

   task automatic test_wrap;
      bit hit;
      out_ready = 1'b1; imem_gnt = 1'b0; lat = 1;
      redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
      exp_q.delete();
      cyc(1);
      redirect = 1'b0;
      total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr0: got %h want fffffffc", imem_addr); else passed++;
      imem_gnt = 1'b1;
      cyc(1);
      imem_gnt = 1'b0;
      total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr1: got %h want 00000000", imem_addr); else passed++;
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
         cyc(1);
         hit = out_valid;
      end
      total++;
      if (!hit || out_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_out: got valid %b pc %h want fffffffc", hit, out_pc);
      else passed++;
      cyc(4);
   endtask

   task automatic test_reset_wait;
      bit seen, hit;
      out_ready = 1'b1; lat = 3; imem_gnt = 1'b1;
      total++; if (imem_req !== 1'b1) $display("FAIL rw_req: got %b want 1", imem_req); else passed++;
      cyc(1);
      imem_gnt = 1'b0; rst = 1'b0;
      exp_q.delete();
      cyc(1);
      rst = 1'b1;
      seen = 1'b0;
      for (int c = 0; c < 5; c++) begin
         cyc(1);
         if (imem_rvalid) seen = 1'b1;
         total++;
         if (count !== 3'd0 || out_valid !== 1'b0)
            $display("FAIL rw_stray: got count %0d valid %b want 0 0", count, out_valid);
         else passed++;
      end
      total++; if (!seen) $display("FAIL rw_seen: got rvalid 0 want a stray rvalid"); else passed++;
      total++; if (imem_addr !== 32'h0) $display("FAIL rw_addr: got %h want 0", imem_addr); else passed++;
      imem_gnt = 1'b1; lat = 1;
      hit = 1'b0;
      for (int c = 0; c < 10 && !hit; c++) begin
         cyc(1);
         hit = out_valid;
      end
      total++;
      if (!hit || out_pc !== 32'h0) $display("FAIL rw_restart: got valid %b pc %h want pc 0", hit, out_pc);
      else passed++;
      imem_gnt = 1'b0;
      cyc(6);
   endtask

   initial begin
      test_reset();
      test_stream();
      test_full();
      test_redirect_wait();
      test_redirect_rvalid();
      test_wrap();
      test_reset_wait();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/mips_fetch_queue.md
# mips_fetch_queue

Parametrised instruction-fetch front end for the next-generation MIPS core, replacing the direct whole-array instruction read of the single-cycle design. It holds a fetch PC and issues one word request at a time to a handshaked instruction memory with variable latency. Returned words are buffered with their PCs in a DEPTH-entry FIFO for the decode stage. Branch and jump redirects flush the FIFO and discard any in-flight response.

## Interface
- DATA_W, 32, instruction word width
- ADDR_W, 32, byte-address width of PC and memory address
- DEPTH, 4, FIFO entries; must be a power of two and at least 2
- RESET_PC, 0, fetch PC loaded on reset
- PC_INC, 4, byte increment per fetched word
---
- clk  in  1  single clock; all state updates on the rising edge
- rst  in  1  synchronous, active-low reset
- imem_req  out  1  request valid
- imem_addr  out  ADDR_W  request byte address; equals fetch_pc
- imem_gnt  in  1  memory accepts the request this cycle
- imem_rvalid  in  1  response word valid
- imem_rdata  in  DATA_W  response word
- redirect  in  1  flush and restart fetch
- redirect_pc  in  ADDR_W  new fetch PC
- out_valid  out  1  FIFO head valid
- out_inst  out  DATA_W  head instruction
- out_pc  out  ADDR_W  head PC
- out_ready  in  1  decode consumes head
- count  out  $clog2(DEPTH+1)  current FIFO occupancy

## Operation
- State: fetch_pc, pend_pc, FSM {IDLE, WAIT, DROP}, FIFO (rd_ptr, wr_ptr, count).
- imem_req = (state==IDLE) && (count < DEPTH) && !redirect. imem_addr = fetch_pc at all times.
- IDLE: when imem_req && imem_gnt, set pend_pc <= fetch_pc and fetch_pc <= fetch_pc + PC_INC (modulo 2^ADDR_W), then go to WAIT.
- WAIT: when imem_rvalid && !redirect, push {imem_rdata, pend_pc} and go to IDLE.
  - redirect && !imem_rvalid: go to DROP.
  - redirect && imem_rvalid: discard the word and go to IDLE.
- DROP: when imem_rvalid, discard the word and go to IDLE. A redirect in DROP only reloads fetch_pc; the state stays DROP.
- Redirect in any state:
  - fetch_pc <= redirect_pc.
  - count, rd_ptr and wr_ptr are cleared.
  - Any same-cycle push or pop is cancelled; redirect has priority.
- Pop occurs when out_valid && out_ready. Push and pop in the same cycle leave count unchanged.
- The FIFO cannot overflow: at most one request is outstanding, and it is issued only when count < DEPTH. The bench asserts that count never exceeds DEPTH.
- imem_rvalid in IDLE is a protocol violation. It is ignored, and the FIFO is unchanged.
- out_valid = (count != 0). out_inst and out_pc are driven from the rd_ptr entry; values are don't-care when out_valid is 0.
- Pointers wrap modulo DEPTH.

## Timing
- Reset (rst==0 at an edge) sets:
  - fetch_pc = RESET_PC, state = IDLE, count = 0, pointers = 0.
  - out_valid = 0, imem_req = 0 while rst is low.
- Reset mid-transaction abandons the outstanding request. A late imem_rvalid then arrives in IDLE and is ignored.
- imem_req may be asserted in the first cycle after reset release.
- Minimum fetch-to-output latency: request granted in cycle n, imem_rvalid in cycle n+1, out_valid in cycle n+2.
- Peak throughput with 1-cycle memory: one word per 2 cycles (IDLE→WAIT→IDLE).
- imem_addr may change while imem_req is high and not granted, but only by redirect. The memory samples the address only on imem_gnt.
- After a redirect, out_valid is 0 in the next cycle. The first redirected word appears no earlier than 2 cycles after the redirect cycle, or later if a DROP must drain first.
- count is registered and updates one cycle after push or pop.

## Test plan
- Reset, memory with gnt=1 and 1-cycle rvalid returning data=addr, out_ready=1: out_pc sequence 0, 4, 8, … and out_inst equals out_pc; out_valid high every other cycle.
- out_ready=0 with DEPTH=4: count reaches 4; imem_req stays 0 while full; in the first cycle with out_ready=1, count drops to 3 and imem_req reasserts next cycle.
- Redirect to 0x100 while in WAIT with rvalid delayed 3 cycles: the late word is dropped, and the next out_pc is 0x100 with no stale entries.
- Redirect to 0x200 in the same cycle as imem_rvalid and a pop: count becomes 0, the word is discarded, and out_pc 0x200 appears after refetch.
- fetch_pc = 0xFFFFFFFC: next request address is 0x00000000 (wrap).
- Reset asserted in WAIT followed by a stray imem_rvalid: count stays 0, out_valid stays 0, and fetch restarts at RESET_PC.
